// File: rtl/dbg_ocimem_engine_if.sv
// CPU-side Avalon-MM slave bus of the debug memory engine.
// Handshake: the master holds chipselect with read or write (and address/data) until a
// cycle where waitrequest is low; that cycle completes the access and readdata is valid in it.
interface dbg_ocimem_engine_if #(
    parameter int AW = 8
);
    logic [AW-1:0] address;
    logic          chipselect;
    logic          read;
    logic          write;
    logic [31:0]   writedata;
    logic [3:0]    byteenable;
    logic          debugaccess;
    logic [31:0]   readdata;
    logic          waitrequest;

    modport master (
        output address, chipselect, read, write, writedata, byteenable, debugaccess,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, chipselect, read, write, writedata, byteenable, debugaccess,
        output readdata, waitrequest
    );
endinterface

// File: rtl/dbg_ocimem_engine.sv
// Debug RAM shared between JTAG (jdo + take_* strobes) and a CPU Avalon-MM port.
// Optional macro DBG_OCIMEM_CPU_WP_EN: CPU writes without debugaccess are ignored.
module dbg_ocimem_engine #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [37:0]        jdo,
    input  logic               take_action_ocimem_a,
    input  logic               take_action_ocimem_b,
    input  logic               take_no_action_ocimem_a,
    dbg_ocimem_engine_if.slave bus,
    output logic [31:0]        MonDReg,
    output logic               monitor_ready,
    output logic               monitor_error,
    output logic [2:0]         dbg_state_o
);
    typedef enum logic [2:0] {
        IDLE = 3'd0, JRD = 3'd1, JCAP = 3'd2, JWR = 3'd3,
        CRD  = 3'd4, CCAP = 3'd5, CWR = 3'd6
    } state_t;

    localparam bit NPOW2 = (DEPTH & (DEPTH - 1)) != 0;

    state_t        state_q, state_d;
    logic [AW-1:0] mon_addr_q, mon_addr_d, mon_addr_inc, jdo_addr;
    logic [31:0]   wdata_q, wdata_d, mon_dreg_q, mon_dreg_d, ram_q;
    logic          pend_a_q, pend_a_d, pend_b_q, pend_b_d, pend_n_q, pend_n_d;
    logic          ready_q, ready_d, error_q, error_d;
    logic          jdo_oob, cpu_req, take_a_ok, take_b_ok, take_n_ok, any_drop;
    logic          jwr_start, jrd_start, cpu_wr_ok, cwr_en;
    logic [31:0]   mem [DEPTH];

`ifdef DBG_OCIMEM_CPU_WP_EN
    assign cpu_wr_ok = bus.debugaccess;
`else
    assign cpu_wr_ok = 1'b1;
    logic unused_debugaccess;
    assign unused_debugaccess = bus.debugaccess;
`endif

    logic unused_jdo;
    assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

    assign jdo_addr     = jdo[AW+8:9];
    assign jdo_oob      = NPOW2 && (32'(jdo_addr) >= 32'(DEPTH));
    assign take_a_ok    = take_action_ocimem_a & ~pend_a_q;
    assign take_b_ok    = take_action_ocimem_b & ~pend_b_q;
    assign take_n_ok    = take_no_action_ocimem_a & ~pend_n_q;
    assign any_drop     = (take_action_ocimem_a & pend_a_q) | (take_action_ocimem_b & pend_b_q)
                        | (take_no_action_ocimem_a & pend_n_q);
    assign cpu_req      = bus.chipselect & (bus.read | bus.write);
    assign mon_addr_inc = (mon_addr_q == AW'(DEPTH - 1)) ? '0 : mon_addr_q + AW'(1);

    // A write strobe is served in the cycle it arrives so it wins against a same-cycle CPU request.
    assign jwr_start = (state_q == IDLE) & (pend_b_q | take_b_ok);
    assign jrd_start = (state_q == IDLE) & ~jwr_start & (pend_a_q | pend_n_q);
    assign cwr_en    = (state_q == CWR) & bus.write & cpu_wr_ok;

    always_comb begin
        state_d    = state_q;
        mon_addr_d = mon_addr_q;
        wdata_d    = wdata_q;
        mon_dreg_d = mon_dreg_q;
        pend_a_d   = pend_a_q;
        pend_b_d   = pend_b_q;
        pend_n_d   = pend_n_q;
        ready_d    = ready_q;
        error_d    = error_q;
        case (state_q)
            IDLE: begin
                if (jwr_start) begin
                    state_d  = JWR;
                    pend_b_d = 1'b0;
                end else if (jrd_start) begin
                    state_d = JRD;
                    if (pend_a_q) pend_a_d = 1'b0;
                    else          pend_n_d = 1'b0;
                end else if (cpu_req) begin
                    state_d = bus.read ? CRD : CWR;
                end
            end
            JRD:  state_d = JCAP;
            JCAP: begin
                state_d    = IDLE;
                mon_dreg_d = ram_q;
                ready_d    = 1'b1;
                mon_addr_d = mon_addr_inc;
            end
            JWR: begin
                state_d    = IDLE;
                mon_addr_d = mon_addr_inc;
            end
            CRD:  state_d = CCAP;
            CCAP: state_d = IDLE;
            CWR:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (take_b_ok) begin
            wdata_d = jdo[34:3];
            if (!jwr_start) pend_b_d = 1'b1;
        end
        if (take_n_ok) pend_n_d = 1'b1;
        // A new address load overrides any same-cycle increment and clears status.
        if (take_a_ok) begin
            ready_d = 1'b0;
            error_d = jdo_oob;
            if (!jdo_oob) begin
                mon_addr_d = jdo_addr;
                pend_a_d   = jdo[35];
            end
        end
        if (any_drop) error_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            mon_addr_q <= '0;
            wdata_q    <= '0;
            mon_dreg_q <= '0;
            pend_a_q   <= 1'b0;
            pend_b_q   <= 1'b0;
            pend_n_q   <= 1'b0;
            ready_q    <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            mon_addr_q <= mon_addr_d;
            wdata_q    <= wdata_d;
            mon_dreg_q <= mon_dreg_d;
            pend_a_q   <= pend_a_d;
            pend_b_q   <= pend_b_d;
            pend_n_q   <= pend_n_d;
            ready_q    <= ready_d;
            error_q    <= error_d;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == JWR) begin
            mem[mon_addr_q] <= wdata_q;
        end else if (cwr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.byteenable[b]) mem[bus.address][8*b +: 8] <= bus.writedata[8*b +: 8];
            end
        end
    end

    // Single shared read port; the registered word doubles as the CPU readdata.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                ram_q <= '0;
        else if (state_q == JRD)  ram_q <= mem[mon_addr_q];
        else if (state_q == CRD)  ram_q <= mem[bus.address];
    end

    assign bus.readdata    = ram_q;
    assign bus.waitrequest = cpu_req & ~((state_q == CCAP) | (state_q == CWR));
    assign MonDReg         = mon_dreg_q;
    assign monitor_ready   = ready_q;
    assign monitor_error   = error_q;
    assign dbg_state_o     = state_q;
endmodule

// File: tb/tb_dbg_ocimem_engine.sv
// Scoreboard bench for dbg_ocimem_engine: drivers push expectations, monitors pop and compare.
module tb_dbg_ocimem_engine;
    localparam int AW = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [37:0] jdo;
    logic        take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
    logic [31:0] mon_dreg;
    logic        mon_ready, mon_error;
    logic [2:0]  dbg_state;

    dbg_ocimem_engine_if #(.AW(AW)) bus ();

    dbg_ocimem_engine #(.DEPTH(256), .AW(AW)) dut (
        .clk                     (clk),
        .reset                   (rst),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .bus                     (bus),
        .MonDReg                 (mon_dreg),
        .monitor_ready           (mon_ready),
        .monitor_error           (mon_error),
        .dbg_state_o             (dbg_state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] cpu_exp_q[$];
    logic [31:0] jtag_exp_q[$];
    int          jtag_due_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitors: CPU read completes when the request sees waitrequest low; JTAG data is due 3 edges after the strobe.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.chipselect && bus.read && !bus.waitrequest) begin
                if (cpu_exp_q.size() == 0) check("cpu_rd_unexpected", 32'(cpu_exp_q.size()), 32'd1);
                else                       check("cpu_rd_data", bus.readdata, cpu_exp_q.pop_front());
            end
            if (jtag_due_q.size() != 0 && cyc >= jtag_due_q[0]) begin
                void'(jtag_due_q.pop_front());
                check("jtag_ready", 32'(mon_ready), 32'd1);
                check("jtag_mondreg", mon_dreg, jtag_exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic jtag_set_addr(input logic [7:0] a, input logic rd);
        jdo = '0;
        jdo[35] = rd;
        jdo[AW+8:9] = a;
        take_action_ocimem_a = 1'b1;
        tick();
        take_action_ocimem_a = 1'b0;
    endtask

    task automatic jtag_read_at(input logic [7:0] a, input logic [31:0] exp);
        jtag_set_addr(a, 1'b1);
        jtag_exp_q.push_back(exp);
        jtag_due_q.push_back(cyc + 3);
        idle(2);
        check("jtag_ready_early", 32'(mon_ready), 32'd0);
        idle(2);
    endtask

    task automatic jtag_next(input logic [31:0] exp);
        jdo = '0;
        take_no_action_ocimem_a = 1'b1;
        tick();
        take_no_action_ocimem_a = 1'b0;
        jtag_exp_q.push_back(exp);
        jtag_due_q.push_back(cyc + 3);
        idle(4);
    endtask

    task automatic jtag_write(input logic [31:0] d);
        jdo = '0;
        jdo[34:3] = d;
        take_action_ocimem_b = 1'b1;
        tick();
        take_action_ocimem_b = 1'b0;
        idle(1);
    endtask

    task automatic cpu_access(input logic is_rd, input logic [7:0] a, input logic [31:0] d,
                              input logic [3:0] be, input logic dbg, input int exp_waits);
        int  waits = 0;
        int  i     = 0;
        bit  done  = 0;
        if (is_rd) cpu_exp_q.push_back(d);
        bus.address     = a;
        bus.writedata   = is_rd ? 32'h0 : d;
        bus.byteenable  = be;
        bus.debugaccess = dbg;
        bus.chipselect  = 1'b1;
        bus.read        = is_rd;
        bus.write       = ~is_rd;
        while (!done && i < 40) begin
            @(negedge clk);
            if (!bus.waitrequest) done = 1;
            else                  waits++;
            i++;
        end
        check(is_rd ? "cpu_rd_done" : "cpu_wr_done", 32'(done), 32'd1);
        tick();
        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
        bus.write      = 1'b0;
        check(is_rd ? "cpu_rd_waits" : "cpu_wr_waits", 32'(waits), 32'(exp_waits));
    endtask

    task automatic cpu_read(input logic [7:0] a, input logic [31:0] exp, input int exp_waits);
        cpu_access(1'b1, a, exp, 4'hF, 1'b1, exp_waits);
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be,
                             input logic dbg);
        cpu_access(1'b0, a, d, be, dbg, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exhausted, required $finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        jdo = '0;
        take_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        bus.address = '0;
        bus.chipselect = 1'b0;
        bus.read = 1'b0;
        bus.write = 1'b0;
        bus.writedata = '0;
        bus.byteenable = '0;
        bus.debugaccess = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_mondreg", mon_dreg, 32'h0);
        check("rst_ready", 32'(mon_ready), 32'd0);
        check("rst_error", 32'(mon_error), 32'd0);
        check("rst_readdata", bus.readdata, 32'h0);
        check("rst_waitreq", 32'(bus.waitrequest), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);

        // Known words used later to observe mon_addr through no_action reads.
        cpu_write(8'h12, 32'hCAFE0012, 4'hF, 1'b1);
        cpu_write(8'h01, 32'h0BAD0001, 4'hF, 1'b1);
        cpu_write(8'h22, 32'h22222222, 4'hF, 1'b1);

        jtag_set_addr(8'h10, 1'b0);
        idle(1);
        jtag_write(32'hDEADBEEF);
        jtag_write(32'h12345678);
        jtag_next(32'hCAFE0012);
        cpu_read(8'h10, 32'hDEADBEEF, 2);
        cpu_read(8'h11, 32'h12345678, 2);

        jtag_read_at(8'h10, 32'hDEADBEEF);
        jtag_next(32'h12345678);
        check("no_error_after_reads", 32'(mon_error), 32'd0);

        jtag_set_addr(8'hFF, 1'b0);
        idle(1);
        jtag_write(32'hF00000FF);
        jtag_write(32'h0000A000);
        jtag_next(32'h0BAD0001);
        cpu_read(8'hFF, 32'hF00000FF, 2);
        cpu_read(8'h00, 32'h0000A000, 2);

        // CPU read and JTAG write presented in the same cycle.
        jtag_set_addr(8'h20, 1'b0);
        idle(1);
        fork
            cpu_read(8'h11, 32'h12345678, 4);
            begin
                jdo = '0;
                jdo[34:3] = 32'h55AA55AA;
                take_action_ocimem_b = 1'b1;
                tick();
                take_action_ocimem_b = 1'b0;
            end
        join
        cpu_read(8'h20, 32'h55AA55AA, 2);

        // Two write strobes on back-to-back cycles while a CPU read is in flight.
        fork
            cpu_read(8'h20, 32'h55AA55AA, 2);
            begin
                tick();
                jdo = '0;
                jdo[34:3] = 32'h600D0021;
                take_action_ocimem_b = 1'b1;
                tick();
                jdo[34:3] = 32'hBAD00022;
                tick();
                take_action_ocimem_b = 1'b0;
            end
        join
        check("overrun_error", 32'(mon_error), 32'd1);
        cpu_read(8'h21, 32'h600D0021, 4);
        jtag_next(32'h22222222);
        jtag_set_addr(8'h40, 1'b0);
        idle(1);
        check("error_cleared", 32'(mon_error), 32'd0);
        check("ready_cleared", 32'(mon_ready), 32'd0);

        cpu_write(8'h00, 32'h00000000, 4'hF, 1'b1);
        cpu_write(8'h00, 32'hAABBCCDD, 4'b0101, 1'b1);
        cpu_read(8'h00, 32'h00BB00DD, 2);
        cpu_write(8'h00, 32'hFFFFFFFF, 4'hF, 1'b0);
`ifdef DBG_OCIMEM_CPU_WP_EN
        cpu_read(8'h00, 32'h00BB00DD, 2);
`else
        cpu_read(8'h00, 32'hFFFFFFFF, 2);
`endif

        // Reset while a JTAG write is in JWR: the write must not land.
        cpu_write(8'h30, 32'h00000000, 4'hF, 1'b1);
        jtag_set_addr(8'h30, 1'b0);
        idle(1);
        jdo = '0;
        jdo[34:3] = 32'h77777777;
        take_action_ocimem_b = 1'b1;
        tick();
        take_action_ocimem_b = 1'b0;
        check("state_jwr", 32'(dbg_state), 32'd3);
        rst = 1'b1;
        #2;
        check("midrst_state", 32'(dbg_state), 32'd0);
        check("midrst_mondreg", mon_dreg, 32'h0);
        check("midrst_readdata", bus.readdata, 32'h0);
        tick();
        rst = 1'b0;
        cpu_read(8'h30, 32'h00000000, 2);

        idle(5);
        check("cpu_q_empty", 32'(cpu_exp_q.size()), 32'd0);
        check("jtag_q_empty", 32'(jtag_due_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
